// File: rtl/pim_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing the single PIM macro port
// between the CPU and the SPI host bridge; one outstanding access at a time.
module pim_port_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WD,
    output logic              CPU_GNT,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RD,
    input  logic              SPI_REQ,
    input  logic              SPI_WE,
    input  logic [ADDR_W-1:0] SPI_ADDR,
    input  logic [DATA_W-1:0] SPI_WD,
    output logic              SPI_GNT,
    output logic              SPI_RVALID,
    output logic [DATA_W-1:0] SPI_RD,
    input  logic              SPI_LOCK,
    output logic              PIMEN,
    output logic              PIMWE,
    output logic [ADDR_W-1:0] PIMADDR,
    output logic [DATA_W-1:0] PIMWD,
    input  logic [DATA_W-1:0] PIMRD,
    output logic              BUSY
);

    localparam int unsigned LAT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RWAIT
    } state_t;

    state_t             state_q, state_d;
    logic               last_spi_q, last_spi_d;   // last grant, also owner of the access in flight
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

    logic               cpu_gnt_d, spi_gnt_d;
    logic               cpu_rvalid_d, spi_rvalid_d;
    logic [DATA_W-1:0]  cpu_rd_d, spi_rd_d;
    logic               pim_en_d, pim_we_d;
    logic [ADDR_W-1:0]  pim_addr_d;
    logic [DATA_W-1:0]  pim_wd_d;
    logic               busy_d;

    logic               cpu_elig, spi_elig, pick_spi;

    // Eligibility and tie-break: on a tie the side not granted last wins
    assign cpu_elig = CPU_REQ && !SPI_LOCK;
    assign spi_elig = SPI_REQ;
    assign pick_spi = spi_elig && (!cpu_elig || !last_spi_q);

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        last_spi_d   = last_spi_q;
        lat_cnt_d    = lat_cnt_q;
        cpu_gnt_d    = 1'b0;
        spi_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        spi_rvalid_d = 1'b0;
        cpu_rd_d     = CPU_RD;
        spi_rd_d     = SPI_RD;
        pim_en_d     = 1'b0;
        pim_we_d     = 1'b0;
        pim_addr_d   = PIMADDR;
        pim_wd_d     = PIMWD;

        case (state_q)
            S_IDLE: begin
                if (cpu_elig || spi_elig) begin
                    state_d    = S_ACCESS;
                    last_spi_d = pick_spi;
                    cpu_gnt_d  = !pick_spi;
                    spi_gnt_d  = pick_spi;
                    pim_en_d   = 1'b1;
                    pim_we_d   = pick_spi ? SPI_WE   : CPU_WE;
                    pim_addr_d = pick_spi ? SPI_ADDR : CPU_ADDR;
                    pim_wd_d   = pick_spi ? SPI_WD   : CPU_WD;
                end
            end
            S_ACCESS: begin
                if (PIMWE) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_RWAIT;
                    lat_cnt_d = LAT_W'(RD_LAT);
                end
            end
            S_RWAIT: begin
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d   = S_IDLE;
                    lat_cnt_d = '0;
                    if (last_spi_q) begin
                        spi_rvalid_d = 1'b1;
                        spi_rd_d     = PIMRD;
                    end else begin
                        cpu_rvalid_d = 1'b1;
                        cpu_rd_d     = PIMRD;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            last_spi_q <= 1'b1;
            lat_cnt_q  <= '0;
            CPU_GNT    <= 1'b0;
            SPI_GNT    <= 1'b0;
            CPU_RVALID <= 1'b0;
            SPI_RVALID <= 1'b0;
            CPU_RD     <= '0;
            SPI_RD     <= '0;
            PIMEN      <= 1'b0;
            PIMWE      <= 1'b0;
            PIMADDR    <= '0;
            PIMWD      <= '0;
            BUSY       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_spi_q <= last_spi_d;
            lat_cnt_q  <= lat_cnt_d;
            CPU_GNT    <= cpu_gnt_d;
            SPI_GNT    <= spi_gnt_d;
            CPU_RVALID <= cpu_rvalid_d;
            SPI_RVALID <= spi_rvalid_d;
            CPU_RD     <= cpu_rd_d;
            SPI_RD     <= spi_rd_d;
            PIMEN      <= pim_en_d;
            PIMWE      <= pim_we_d;
            PIMADDR    <= pim_addr_d;
            PIMWD      <= pim_wd_d;
            BUSY       <= busy_d;
        end
    end

endmodule

// File: tb/tb_pim_port_arbiter.sv
// Directed bench for pim_port_arbiter: three builds (RD_LAT 1, 2, 7) share the
// requester stimulus, each with its own PIM macro model; index 1 is the main build.
module tb_pim_port_arbiter;

    localparam int M = 1;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, spi_req, spi_we, spi_lock;
    logic [11:0] cpu_addr, spi_addr;
    logic [31:0] cpu_wd, spi_wd;

    logic [2:0]  cpu_gnt, spi_gnt, cpu_rvalid, spi_rvalid, pim_en, pim_we, busy;
    logic [31:0] cpu_rd [3];
    logic [31:0] spi_rd [3];
    logic [31:0] pim_wd [3];
    logic [31:0] pim_rd [3];
    logic [11:0] pim_addr [3];

    int errors = 0;
    int checks = 0;

    function automatic int unsigned lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 7);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 7);
        logic [31:0]    mem [4096];
        logic [LAT-1:0] rpipe;

        pim_port_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(LAT)) u_dut (
            .CLK        (clk),
            .RST        (rst),
            .CPU_REQ    (cpu_req),
            .CPU_WE     (cpu_we),
            .CPU_ADDR   (cpu_addr),
            .CPU_WD     (cpu_wd),
            .CPU_GNT    (cpu_gnt[g]),
            .CPU_RVALID (cpu_rvalid[g]),
            .CPU_RD     (cpu_rd[g]),
            .SPI_REQ    (spi_req),
            .SPI_WE     (spi_we),
            .SPI_ADDR   (spi_addr),
            .SPI_WD     (spi_wd),
            .SPI_GNT    (spi_gnt[g]),
            .SPI_RVALID (spi_rvalid[g]),
            .SPI_RD     (spi_rd[g]),
            .SPI_LOCK   (spi_lock),
            .PIMEN      (pim_en[g]),
            .PIMWE      (pim_we[g]),
            .PIMADDR    (pim_addr[g]),
            .PIMWD      (pim_wd[g]),
            .PIMRD      (pim_rd[g]),
            .BUSY       (busy[g])
        );

        // PIM macro model: read data valid only in cycle PIMEN + LAT
        always @(posedge clk) begin
            if (pim_en[g] && pim_we[g]) mem[pim_addr[g]] <= pim_wd[g];
            rpipe <= (rpipe << 1) | LAT'(pim_en[g] && !pim_we[g]);
        end
        assign pim_rd[g] = rpipe[LAT-1] ? mem[pim_addr[g]] : 32'hBAD0_BAD0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; spi_lock = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h111; cpu_wd = 32'h1111_1111;
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = 12'h222; spi_wd = 32'h2222_2222;

        // Reset with both requesting
        tick(); tick(); tick();
        check1("rst_cpu_gnt", cpu_gnt[M], 1'b0);
        check1("rst_spi_gnt", spi_gnt[M], 1'b0);
        check1("rst_pimen", pim_en[M], 1'b0);
        check1("rst_busy", busy[M], 1'b0);
        check32("rst_pimaddr", 32'(pim_addr[M]), 32'h0);
        check32("rst_cpu_rd", cpu_rd[M], 32'h0);
        rst = 1'b0;

        // Tie round-robin, starting with CPU right after reset
        for (int k = 0; k < 4; k++) begin
            tick();
            check1($sformatf("rr%0d_cpu_gnt", k), cpu_gnt[M], (k % 2) == 0);
            check1($sformatf("rr%0d_spi_gnt", k), spi_gnt[M], (k % 2) == 1);
            check1($sformatf("rr%0d_pimen", k), pim_en[M], 1'b1);
            check32($sformatf("rr%0d_addr", k), 32'(pim_addr[M]),
                    ((k % 2) == 0) ? 32'h111 : 32'h222);
            if (k == 3) begin cpu_req = 1'b0; spi_req = 1'b0; end
            tick();
            check1($sformatf("rr%0d_idle_gnt", k), cpu_gnt[M] | spi_gnt[M], 1'b0);
            check1($sformatf("rr%0d_idle_busy", k), busy[M], 1'b0);
        end

        // CPU write 0x0A5 then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0A5; cpu_wd = 32'hDEAD_BEEF;
        tick();
        check1("wr_cpu_gnt", cpu_gnt[M], 1'b1);
        check1("wr_pimen", pim_en[M], 1'b1);
        check1("wr_pimwe", pim_we[M], 1'b1);
        check32("wr_addr", 32'(pim_addr[M]), 32'h0A5);
        check32("wr_wd", pim_wd[M], 32'hDEAD_BEEF);
        check1("wr_busy", busy[M], 1'b1);
        cpu_req = 1'b0;
        tick();
        check1("wr_after_pimen", pim_en[M], 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0;
        tick();
        check1("rd_cpu_gnt", cpu_gnt[M], 1'b1);
        check1("rd_pimwe", pim_we[M], 1'b0);
        cpu_req = 1'b0;
        tick();
        check1("rd_wait1_busy", busy[M], 1'b1);
        check1("rd_wait1_pimen", pim_en[M], 1'b0);
        tick();
        check1("rd_wait2_rvalid", cpu_rvalid[M], 1'b0);
        tick();
        check1("rd_rvalid", cpu_rvalid[M], 1'b1);
        check32("rd_data", cpu_rd[M], 32'hDEAD_BEEF);
        check1("rd_rvalid_busy", busy[M], 1'b0);
        check1("rd_spi_rvalid", spi_rvalid[M], 1'b0);
        check32("rd_spi_rd", spi_rd[M], 32'h0);
        tick();
        check1("rd_rvalid_pulse", cpu_rvalid[M], 1'b0);
        check32("rd_data_hold", cpu_rd[M], 32'hDEAD_BEEF);

        // SPI_LOCK: SPI granted twice with both requesting
        spi_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h333; cpu_wd = 32'h3333_3333;
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = 12'h444; spi_wd = 32'h4444_4444;
        tick();
        check1("lock1_spi_gnt", spi_gnt[M], 1'b1);
        check1("lock1_cpu_gnt", cpu_gnt[M], 1'b0);
        tick();
        tick();
        check1("lock2_spi_gnt", spi_gnt[M], 1'b1);
        check1("lock2_cpu_gnt", cpu_gnt[M], 1'b0);
        check32("lock2_addr", 32'(pim_addr[M]), 32'h444);
        spi_req = 1'b0; spi_lock = 1'b0;
        tick();
        check1("unlock_idle_gnt", cpu_gnt[M], 1'b0);
        tick();
        check1("unlock_cpu_gnt", cpu_gnt[M], 1'b1);
        check32("unlock_addr", 32'(pim_addr[M]), 32'h333);
        cpu_req = 1'b0;
        tick();

        // LOCK raised during a CPU read does not abort it
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h111;
        tick();
        check1("lrd_cpu_gnt", cpu_gnt[M], 1'b1);
        cpu_req = 1'b0; spi_lock = 1'b1;
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = 12'h555; spi_wd = 32'h5555_5555;
        tick();
        check1("lrd_wait_spi_gnt", spi_gnt[M], 1'b0);
        tick();
        tick();
        check1("lrd_cpu_rvalid", cpu_rvalid[M], 1'b1);
        check32("lrd_cpu_rd", cpu_rd[M], 32'h1111_1111);
        check1("lrd_spi_rvalid", spi_rvalid[M], 1'b0);
        tick();
        check1("lrd_next_spi_gnt", spi_gnt[M], 1'b1);
        check1("lrd_next_cpu_gnt", cpu_gnt[M], 1'b0);
        spi_req = 1'b0; spi_lock = 1'b0;
        tick();

        // Reset in the RWAIT cycle of an SPI read
        spi_req = 1'b1; spi_we = 1'b0; spi_addr = 12'h222;
        tick();
        check1("mr_spi_gnt", spi_gnt[M], 1'b1);
        spi_req = 1'b0;
        tick();
        check1("mr_rwait_busy", busy[M], 1'b1);
        rst = 1'b1;
        tick();
        check1("mr_rst_busy", busy[M], 1'b0);
        check32("mr_rst_cpu_rd", cpu_rd[M], 32'h0);
        rst = 1'b0;
        tick();
        check1("mr_spi_rvalid_a", spi_rvalid[M], 1'b0);
        check1("mr_cpu_rvalid_a", cpu_rvalid[M], 1'b0);
        check1("mr_busy_a", busy[M], 1'b0);
        check32("mr_spi_rd", spi_rd[M], 32'h0);
        check32("mr_cpu_rd", cpu_rd[M], 32'h0);
        tick();
        check1("mr_spi_rvalid_b", spi_rvalid[M], 1'b0);

        // Read latency across builds: SPI write then read of 0x3FF
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = 12'h3FF; spi_wd = 32'h1234_5678;
        tick();
        for (int g = 0; g < 3; g++) check1($sformatf("lat%0d_wr_gnt", g), spi_gnt[g], 1'b1);
        spi_req = 1'b0;
        tick();
        spi_req = 1'b1; spi_we = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) spi_req = 1'b0;
            for (int g = 0; g < 3; g++) begin
                check1($sformatf("lat%0d_n%0d_rvalid", lat_of(g), n), spi_rvalid[g],
                       n == int'(lat_of(g)) + 2);
                if (n == int'(lat_of(g)) + 2)
                    check32($sformatf("lat%0d_rd", lat_of(g)), spi_rd[g], 32'h1234_5678);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
